// File: rtl/sobel_pkg.sv
//------------------------------------------------------------------------------
// sobel_pkg : shared types and default geometry for the Sobel window controller
// Revision  : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package sobel_pkg;

  localparam int DEF_IMG_W = 640;
  localparam int DEF_IMG_H = 480;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic valid;
    logic border;
    logic sof;
    logic eof;
  } tag_t;

  localparam tag_t TAG_NONE = '0;

endpackage

`default_nettype wire

// File: rtl/sobel_tag_pipe.sv
//------------------------------------------------------------------------------
// sobel_tag_pipe : LAT-stage tag delay line with advance enable and sync clear
// Revision       : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module sobel_tag_pipe
  import sobel_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic adv,
  input  logic clr,
  input  tag_t din,
  output tag_t dout
);

  tag_t r_stage [LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) r_stage[i] <= TAG_NONE;
    end else if (clr) begin
      for (int i = 0; i < LAT; i++) r_stage[i] <= TAG_NONE;
    end else if (adv) begin
      r_stage[0] <= din;
      for (int i = 1; i < LAT; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign dout = r_stage[LAT-1];

endmodule

`default_nettype wire

// File: rtl/sobel_window_ctrl.sv
//------------------------------------------------------------------------------
// sobel_window_ctrl : pixel-stream sequencer for the 3x3 Sobel window datapath
// Revision          : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int LAT   = 2,
  parameter int CW    = $clog2(IMG_W),
  parameter int RW    = $clog2(IMG_H + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_sof,
  output logic          in_ready,
  input  logic          out_ready,
  output logic          lb_we,
  output logic [CW-1:0] lb_addr,
  output logic          win_shift,
  output logic          out_valid,
  output logic          out_border,
  output logic          out_sof,
  output logic          out_eof,
  output logic          busy,
  output logic          err_sof
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_VIRT = RW'(IMG_H);

  state_t        r_state;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_ccol;
  logic [RW-1:0] r_crow;
  logic          r_err;

  logic w_in_ready;
  logic w_accept;
  logic w_sof_step;
  logic w_restart;
  logic w_step;
  logic w_produce;
  logic w_last_flush;
  tag_t w_tag;
  tag_t w_tag_out;

  // Combinational handshakes are gated by rst so every output reads 0 in reset.
  assign w_in_ready = rst && out_ready && (r_state != FLUSH);
  assign w_accept   = in_valid && w_in_ready;
  assign w_sof_step = w_accept && in_sof;
  assign w_restart  = w_sof_step && (r_state == RUN);

  always_comb begin
    w_step = 1'b0;
    case (r_state)
      IDLE:    w_step = w_sof_step;
      RUN:     w_step = w_accept;
      FLUSH:   w_step = rst && out_ready;
      default: w_step = 1'b0;
    endcase
  end

  // A step yields a result once the window holds the centre: k >= IMG_W+1.
  assign w_produce = !w_sof_step &&
                     ((r_state == FLUSH) || (r_row > RW'(1)) ||
                      ((r_row == RW'(1)) && (r_col != '0)));

  always_comb begin
    w_tag        = TAG_NONE;
    w_tag.valid  = w_step && w_produce;
    w_tag.border = w_tag.valid &&
                   ((r_crow == '0) || (r_crow == ROW_LAST) ||
                    (r_ccol == '0) || (r_ccol == COL_LAST));
    w_tag.sof    = w_tag.valid && (r_crow == '0) && (r_ccol == '0);
    w_tag.eof    = w_tag.valid && (r_crow == ROW_LAST) && (r_ccol == COL_LAST);
  end

  // The final flush step is the one that emits the bottom-right centre.
  assign w_last_flush = (r_state == FLUSH) && w_step &&
                        (r_crow == ROW_LAST) && (r_ccol == COL_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_ccol  <= '0;
      r_crow  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_restart;
      if (w_sof_step) begin
        r_state <= RUN;
        r_col   <= CW'(1);
        r_row   <= '0;
        r_ccol  <= '0;
        r_crow  <= '0;
      end else if (w_last_flush) begin
        r_state <= IDLE;
        r_col   <= '0;
        r_row   <= '0;
        r_ccol  <= '0;
        r_crow  <= '0;
      end else if (w_step) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          if (r_row != ROW_VIRT) r_row <= r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
        if (w_produce) begin
          if (r_ccol == COL_LAST) begin
            r_ccol <= '0;
            r_crow <= r_crow + RW'(1);
          end else begin
            r_ccol <= r_ccol + CW'(1);
          end
        end
        if ((r_state == RUN) && (r_row == ROW_LAST) && (r_col == COL_LAST))
          r_state <= FLUSH;
      end
    end
  end

  sobel_tag_pipe #(
    .LAT (LAT)
  ) u_tag_pipe (
    .clk  (clk),
    .rst  (rst),
    .adv  (out_ready),
    .clr  (w_restart),
    .din  (w_tag),
    .dout (w_tag_out)
  );

  assign in_ready   = w_in_ready;
  assign win_shift  = w_step;
  assign lb_we      = w_step;
  assign lb_addr    = w_sof_step ? '0 : r_col;
  assign out_valid  = w_tag_out.valid;
  assign out_border = w_tag_out.border;
  assign out_sof    = w_tag_out.sof;
  assign out_eof    = w_tag_out.eof;
  assign busy       = (r_state != IDLE);
  assign err_sof    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_sobel_window_ctrl.sv
//------------------------------------------------------------------------------
// tb_sobel_window_ctrl : directed and random checks against a linear-index model
// Revision             : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sobel_window_ctrl;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int L  = 2;
  localparam int CW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready, lb_we, win_shift, out_valid, out_border;
  logic          out_sof, out_eof, busy, err_sof;
  logic [CW-1:0] lb_addr;

  sobel_window_ctrl #(.IMG_W(W), .IMG_H(H), .LAT(L)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_ready   (in_ready),
    .out_ready  (out_ready),
    .lb_we      (lb_we),
    .lb_addr    (lb_addr),
    .win_shift  (win_shift),
    .out_valid  (out_valid),
    .out_border (out_border),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .busy       (busy),
    .err_sof    (err_sof)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: mode 0/1/2 = idle/run/flush, m_k = linear step index of next step.
  int m_mode, m_k, m_pipe[L];
  bit m_err;
  bit e_step, e_restart, e_sofstep;
  int e_tag;
  int cyc = 0;

  // Per-scenario observations, relative to base cycle.
  int base, n_res, n_sof, n_eof, n_inner, n_step, n_err;
  int sof_at, eof_at, inner_first, busy_last;

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_err = 0;
    for (int i = 0; i < L; i++) m_pipe[i] = 0;
  endtask

  task automatic eval_and_check();
    int kk, c, cr, cc, rel;
    bit er, acc;
    if (!rst) model_reset();
    er        = rst && out_ready && (m_mode != 2);
    acc       = in_valid && er;
    e_sofstep = acc && in_sof;
    e_step    = (m_mode == 0) ? e_sofstep : (m_mode == 1) ? acc : (rst && out_ready);
    e_restart = e_sofstep && (m_mode == 1);
    kk        = e_sofstep ? 0 : m_k;
    c         = kk - (W + 1);
    e_tag     = 0;
    if (e_step && c >= 0) begin
      cr = c / W; cc = c % W;
      e_tag = 8 | ((cr == 0 || cr == H-1 || cc == 0 || cc == W-1) ? 4 : 0)
                | ((c == 0) ? 2 : 0) | ((c == W*H-1) ? 1 : 0);
    end
    check_eq("in_ready", in_ready, er);
    check_eq("win_shift", win_shift, e_step);
    check_eq("lb_we", lb_we, e_step);
    if (e_step) check_eq("lb_addr", lb_addr, kk % W);
    check_eq("out_tags", {out_valid, out_border, out_sof, out_eof}, m_pipe[L-1]);
    check_eq("busy", busy, m_mode != 0);
    check_eq("err_sof", err_sof, m_err);
    rel = cyc - base;
    if (rst && win_shift) n_step++;
    if (rst && err_sof) n_err++;
    if (rst && busy) busy_last = rel;
    if (rst && out_ready && out_valid) begin
      n_res++;
      if (out_sof) begin n_sof++; sof_at = rel; end
      if (out_eof) begin n_eof++; eof_at = rel; end
      if (!out_border) begin
        if (n_inner == 0) inner_first = rel;
        n_inner++;
      end
    end
  endtask

  task automatic model_update();
    m_err = e_restart;
    if (out_ready) begin
      if (e_restart) begin
        for (int i = 0; i < L; i++) m_pipe[i] = 0;
      end else begin
        for (int i = L-1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
        m_pipe[0] = e_tag;
      end
    end
    if (e_sofstep) begin
      m_mode = 1; m_k = 1;
    end else if (e_step) begin
      if (m_mode == 2 && m_k == H*W + W) begin
        m_mode = 0; m_k = 0;
      end else begin
        m_k++;
        if (m_mode == 1 && m_k == H*W) m_mode = 2;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    eval_and_check();
    @(posedge clk);
    if (rst) model_update();
    cyc++;
    #1;
  endtask

  task automatic drive(input bit v, input bit s, input bit r);
    in_valid = v; in_sof = s; out_ready = r;
    tick();
  endtask

  task automatic start_scn();
    base = cyc; n_res = 0; n_sof = 0; n_eof = 0; n_inner = 0; n_step = 0; n_err = 0;
    sof_at = -1; eof_at = -1; inner_first = -1; busy_last = -1;
  endtask

  task automatic frame(input int total);
    drive(1, 1, 1);
    repeat (total - 1) drive(1, 0, 1);
  endtask

  initial begin
    model_reset();
    start_scn();
    repeat (3) drive(0, 0, 1);
    rst = 1'b1;
    repeat (2) drive(0, 0, 1);

    // Single frame, continuous traffic.
    start_scn();
    frame(25);
    check_eq("s1_results", n_res, 12);
    check_eq("s1_sof_cycle", sof_at, 7);
    check_eq("s1_eof_cycle", eof_at, 18);
    check_eq("s1_inner_count", n_inner, 2);
    check_eq("s1_inner_first", inner_first, 12);
    check_eq("s1_busy_last", busy_last, 16);
    check_eq("s1_steps", n_step, 17);

    // Non-sof pixels in idle are discarded.
    start_scn();
    repeat (5) drive(1, 0, 1);
    check_eq("s2_idle_steps", n_step, 0);
    check_eq("s2_idle_results", n_res, 0);
    start_scn();
    frame(25);
    check_eq("s2_results", n_res, 12);
    check_eq("s2_sof_cycle", sof_at, 7);

    // Downstream stall for three cycles mid-frame.
    start_scn();
    drive(1, 1, 1);
    repeat (2) drive(1, 0, 1);
    repeat (3) drive(1, 0, 0);
    repeat (25) drive(1, 0, 1);
    check_eq("s3_results", n_res, 12);
    check_eq("s3_sof_cycle", sof_at, 10);
    check_eq("s3_eof_cycle", eof_at, 21);

    // Mid-frame sof restarts the frame.
    start_scn();
    drive(1, 1, 1);
    repeat (5) drive(1, 0, 1);
    drive(1, 1, 1);
    repeat (25) drive(1, 0, 1);
    check_eq("s4_err_pulses", n_err, 1);
    check_eq("s4_results", n_res, 12);
    check_eq("s4_sof_cycle", sof_at, 13);
    check_eq("s4_eof_cycle", eof_at, 24);

    // Back-to-back frames.
    start_scn();
    drive(1, 1, 1);
    repeat (16) drive(1, 0, 1);
    drive(1, 1, 1);
    repeat (27) drive(1, 0, 1);
    check_eq("s5_results", n_res, 24);
    check_eq("s5_sofs", n_sof, 2);
    check_eq("s5_eofs", n_eof, 2);
    check_eq("s5_sof2_cycle", sof_at, 24);
    check_eq("s5_eof2_cycle", eof_at, 35);
    check_eq("s5_steps", n_step, 34);

    // Asynchronous reset in the middle of flush.
    start_scn();
    frame(14);
    rst = 1'b0;
    #1;
    check_eq("rst_async_outs",
             {in_ready, lb_we, win_shift, out_valid, out_border, out_sof, out_eof, busy, err_sof},
             0);
    check_eq("rst_async_addr", lb_addr, 0);
    repeat (2) drive(1, 0, 1);
    rst = 1'b1;
    drive(0, 0, 0);
    drive(0, 0, 1);
    check_eq("rst_release_busy", busy, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7,
            $urandom_range(0, 99) < ((m_mode == 0) ? 30 : 2),
            $urandom_range(0, 9) < 8);
    end
    repeat (30) drive(0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
